// File: rtl/clk_mon_pkg.sv
// Shared types and constants for the clk_monitor block.
package clk_mon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2,
    LOST    = 2'd3
  } mon_state_e;

  localparam int SYNC_DEPTH = 2;

  function automatic int streak_w(input int lock_cnt);
    return $clog2(lock_cnt + 1);
  endfunction

endpackage

// File: rtl/clk_mon_sync.sv
// Synchronizes clk_in into the clk domain and emits a one-cycle tick per rising edge.
module clk_mon_sync
  import clk_mon_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clk_in_i,
  output logic sync_o,
  output logic tick_o
);

  logic [SYNC_DEPTH-1:0] sync_q;
  logic [SYNC_DEPTH:0]   fill_q;
  logic                  prev_q;
  logic                  tick_q;
  logic                  primed;

  // Primed only once the sync chain and prev hold real samples, so a clk_in
  // that is already high at reset release cannot look like a rising edge.
  assign primed = fill_q[SYNC_DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      fill_q <= '0;
      prev_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], clk_in_i};
      fill_q <= {fill_q[SYNC_DEPTH-1:0], 1'b1};
      prev_q <= sync_q[SYNC_DEPTH-1];
      tick_q <= primed & sync_q[SYNC_DEPTH-1] & ~prev_q;
    end
  end

  assign sync_o = sync_q[SYNC_DEPTH-1];
  assign tick_o = tick_q;

endmodule

// File: rtl/clk_monitor.sv
// Period/presence monitor for a divided clock: measures period, tracks lock, flags loss.
// Optional duty measurement on high_time is built when CLK_MON_DUTY_EN is defined.
module clk_monitor
  import clk_mon_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int EXP_PERIOD = 200,
  parameter int TOL        = 4,
  parameter int LOCK_CNT   = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_in,
  output logic             tick,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             err,
  output logic             lost,
  output logic [CNT_W-1:0] high_time
);

  localparam int                    SW     = streak_w(LOCK_CNT);
  localparam logic [CNT_W-1:0]      TMO    = CNT_W'(TIMEOUT);
  localparam logic [SW-1:0]         LOCK_N = SW'(LOCK_CNT);
  localparam logic signed [CNT_W:0] EXP_S  = (CNT_W+1)'(EXP_PERIOD);
  localparam logic signed [CNT_W:0] TOL_S  = (CNT_W+1)'(TOL);

  logic                    sync_lvl;
  logic                    tick_w;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]        meas;
  logic signed [CNT_W:0]   diff;
  logic                    in_range;
  logic                    timeout;
  mon_state_e              state_q;
  logic [SW-1:0]           streak_q;
  logic [SW-1:0]           streak_inc;
  logic [CNT_W-1:0]        period_q;
  logic                    pv_q, locked_q, err_q, lost_q;

  clk_mon_sync u_sync (
    .clk      (clk),
    .reset    (reset),
    .clk_in_i (clk_in),
    .sync_o   (sync_lvl),
    .tick_o   (tick_w)
  );

  always_comb begin
    meas       = cnt_q + CNT_W'(1);
    diff       = $signed({1'b0, meas}) - EXP_S;
    in_range   = (diff <= TOL_S) && (diff >= -TOL_S);
    timeout    = (cnt_q == TMO);
    streak_inc = streak_q + SW'(1);
    cnt_d      = cnt_q;
    if (tick_w)        cnt_d = '0;
    else if (!timeout) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // A tick always takes precedence over a coincident timeout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      streak_q <= '0;
      period_q <= '0;
      pv_q     <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      pv_q  <= 1'b0;
      err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (tick_w) state_q <= MEASURE;
        end
        MEASURE: begin
          if (tick_w) begin
            period_q <= meas;
            pv_q     <= 1'b1;
            if (in_range) begin
              streak_q <= streak_inc;
              if (streak_inc == LOCK_N) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
              end
            end else begin
              err_q    <= 1'b1;
              streak_q <= '0;
            end
          end else if (timeout) begin
            lost_q   <= 1'b1;
            locked_q <= 1'b0;
            streak_q <= '0;
            state_q  <= LOST;
          end
        end
        LOCKED: begin
          if (tick_w) begin
            period_q <= meas;
            pv_q     <= 1'b1;
            if (!in_range) begin
              err_q    <= 1'b1;
              locked_q <= 1'b0;
              streak_q <= '0;
              state_q  <= MEASURE;
            end
          end else if (timeout) begin
            lost_q   <= 1'b1;
            locked_q <= 1'b0;
            streak_q <= '0;
            state_q  <= LOST;
          end
        end
        LOST: begin
          if (tick_w) begin
            lost_q  <= 1'b0;
            state_q <= MEASURE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef CLK_MON_DUTY_EN
  logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d, hi_meas, high_q;
  logic             period_upd;

  // The tick cycle itself belongs to the period being closed, like cnt+1.
  always_comb begin
    hi_meas    = hi_cnt_q + CNT_W'(sync_lvl);
    period_upd = tick_w && (state_q == MEASURE || state_q == LOCKED);
    hi_cnt_d   = hi_cnt_q;
    if (tick_w)                 hi_cnt_d = '0;
    else if (hi_cnt_q != TMO)   hi_cnt_d = hi_meas;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_cnt_q <= '0;
      high_q   <= '0;
    end else begin
      hi_cnt_q <= hi_cnt_d;
      if (period_upd) high_q <= hi_meas;
    end
  end

  assign high_time = high_q;
`else
  logic duty_unused;
  assign duty_unused = sync_lvl;
  assign high_time   = '0;
`endif

  assign tick         = tick_w;
  assign period       = period_q;
  assign period_valid = pv_q;
  assign locked       = locked_q;
  assign err          = err_q;
  assign lost         = lost_q;

endmodule

// File: tb/tb_clk_monitor.sv
// Directed bench for clk_monitor with a scoreboard of expected period results.
module tb_clk_monitor;

  localparam int CNT_W    = 32;
  localparam int EXP      = 200;
  localparam int TOL      = 4;
  localparam int LOCK_CNT = 4;
  localparam int TIMEOUT  = 1024;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             clk_in = 1'b1;
  logic             tick;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             locked;
  logic             err;
  logic             lost;
  logic [CNT_W-1:0] high_time;

  always #5 clk = ~clk;

  clk_monitor #(
    .CNT_W(CNT_W), .EXP_PERIOD(EXP), .TOL(TOL), .LOCK_CNT(LOCK_CNT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .clk_in       (clk_in),
    .tick         (tick),
    .period       (period),
    .period_valid (period_valid),
    .locked       (locked),
    .err          (err),
    .lost         (lost),
    .high_time    (high_time)
  );

  typedef struct {
    int per;
    int hi;
    bit er;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   tick_cnt = 0;
  int   err_cnt = 0;
  int   last_tick_cyc = 0;
  int   last_len = 0;
  int   last_hi = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  function automatic bit oor(input int len);
    return (len > EXP + TOL) || (len < EXP - TOL);
  endfunction

  // Each call starts with a rising edge, which closes the previous period.
  task automatic gen(input int hi, input int lo, input bit expv);
    @(negedge clk);
    clk_in = 1'b1;
    if (expv) sb.push_back('{per: last_len, hi: last_hi, er: oor(last_len)});
    last_len = hi + lo;
    last_hi  = hi;
    repeat (hi) @(negedge clk);
    clk_in = 1'b0;
    repeat (lo - 1) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (tick) begin
        tick_cnt++;
        last_tick_cyc = cyc;
      end
      if (err) begin
        err_cnt++;
        chk("err_with_pv", 64'(period_valid), 64'(1));
      end
      if (period_valid) begin
        chk("sb_has_entry", 64'(sb.size() != 0), 64'(1));
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("period", 64'(period), 64'(mon_e.per));
          chk("err", 64'(err), 64'(mon_e.er));
`ifdef CLK_MON_DUTY_EN
          chk("high_time", 64'(high_time), 64'(mon_e.hi));
`else
          chk("high_time", 64'(high_time), 64'(0));
`endif
        end
      end
    end
  end

  initial begin
    int k;
    // Reset with clk_in held high
    reset  = 1'b0;
    clk_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tick", 64'(tick), 64'(0));
    chk("rst_period", 64'(period), 64'(0));
    chk("rst_pv", 64'(period_valid), 64'(0));
    chk("rst_locked", 64'(locked), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_lost", 64'(lost), 64'(0));
    chk("rst_high", 64'(high_time), 64'(0));
    reset = 1'b1;
    repeat (20) @(negedge clk);
    chk("no_spurious_tick", 64'(tick_cnt), 64'(0));
    chk("quiet_period", 64'(period), 64'(0));
    clk_in = 1'b0;
    repeat (20) @(negedge clk);

    // Divider input: first rise has no reference, lock after 4 valid periods
    for (int i = 0; i < 6; i++) begin
      gen(100, 100, i > 0);
      chk("lock_div", 64'(locked), 64'(i >= 4));
    end
    chk("tick_count", 64'(tick_cnt), 64'(6));

    // One short period breaks lock, relock after 4 good periods
    gen(95, 95, 1'b1);
    chk("lock_before_190", 64'(locked), 64'(1));
    gen(100, 100, 1'b1);
    chk("lock_after_190", 64'(locked), 64'(0));
    for (int j = 1; j <= 4; j++) begin
      gen(100, 100, 1'b1);
      chk("relock_190", 64'(locked), 64'(j == 4));
    end

    // Clock stops: lost after timeout
    repeat (800) @(negedge clk);
    chk("lost_early", 64'(lost), 64'(0));
    k = 0;
    while (!lost && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("lost_set", 64'(lost), 64'(1));
    // cnt clears on the edge after tick, reaches TIMEOUT, lost registers one edge later
    chk("lost_latency", 64'(cyc - last_tick_cyc), 64'(TIMEOUT + 2));
    chk("lost_unlocks", 64'(locked), 64'(0));

    gen(100, 100, 1'b0);
    chk("lost_cleared", 64'(lost), 64'(0));
    chk("lock_after_lost", 64'(locked), 64'(0));
    for (int j = 1; j <= 4; j++) begin
      gen(100, 100, 1'b1);
      chk("relock_lost", 64'(locked), 64'(j == 4));
    end

    // 210-cycle periods are out of range
    gen(105, 105, 1'b1);
    chk("lock_before_210", 64'(locked), 64'(1));
    for (int j = 0; j < 3; j++) begin
      gen(105, 105, 1'b1);
      chk("lock_210", 64'(locked), 64'(0));
    end
    chk("err_count_210", 64'(err_cnt), 64'(4));

    // 60/140 duty cycle
    gen(60, 140, 1'b1);
    gen(60, 140, 1'b1);
    gen(60, 140, 1'b1);
    chk("err_count_duty", 64'(err_cnt), 64'(5));

    // Reset mid-measurement discards the partial period
    repeat (30) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_period", 64'(period), 64'(0));
    chk("midrst_locked", 64'(locked), 64'(0));
    chk("midrst_high", 64'(high_time), 64'(0));
    reset = 1'b1;
    repeat (10) @(negedge clk);
    gen(100, 100, 1'b0);
    gen(100, 100, 1'b1);
    gen(100, 100, 1'b1);
    repeat (20) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'(0));
    chk("err_count_final", 64'(err_cnt), 64'(5));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
